// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: FSM state codes, ALU opcodes, flag bit
// positions and a one-hot helper.
package alu_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [3:0] OP_SUB  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_MPYU = 4'h3;
  localparam logic [3:0] OP_MPYS = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'ha;
  localparam logic [3:0] OP_LSR  = 4'hf;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// requester selected by ptr.
module alu_arb_rr
  import alu_arb_pkg::*;
(
  input  logic [1:0] stb,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (stb)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = onehot(ptr);
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between two requesters (IDLE -> ISSUE -> WAIT).
// Optional ALU_ARB_LOCK_EN adds i_req_lock for bounded back-to-back ownership.
//
// state | meaning
// IDLE  | arbitrate, latch winner's op/a/b
// ISSUE | pulse o_alu_ce/o_alu_valid for one cycle
// WAIT  | wait for i_alu_valid or timeout, then respond
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int TIMEOUT     = 8,
  parameter int LOG_TIMEOUT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req_stb,
  input  logic [7:0]  i_req_op,
  input  logic [63:0] i_req_a,
  input  logic [63:0] i_req_b,
`ifdef ALU_ARB_LOCK_EN
  input  logic [1:0]  i_req_lock,
`endif
  output logic [1:0]  o_req_busy,
  output logic        o_alu_ce,
  output logic        o_alu_valid,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  input  logic        i_alu_valid,
  input  logic [31:0] i_alu_c,
  input  logic [3:0]  i_alu_f,
  input  logic        i_alu_illegal,
  output logic [1:0]  o_rsp_valid,
  output logic [31:0] o_rsp_c,
  output logic [3:0]  o_rsp_f,
  output logic        o_rsp_err
);

  localparam logic [LOG_TIMEOUT-1:0] TMO_LAST = LOG_TIMEOUT'(TIMEOUT - 1);

  logic [1:0]             state;
  logic                   rr_ptr;
  logic                   owner;
  logic [LOG_TIMEOUT-1:0] tmo_cnt;
  logic [1:0]             stb_eff;
  logic [1:0]             grant;
  logic                   rsp_done;
  logic                   keep_ptr;

  assign rsp_done = (state == ST_WAIT) && (i_alu_valid || (tmo_cnt == TMO_LAST));

`ifdef ALU_ARB_LOCK_EN
  logic [1:0] lock_cnt;
  logic       lock_hold;

  // The fourth consecutive locked op releases the lock so the other side can get in.
  assign keep_ptr = i_req_lock[owner] && (lock_cnt != 2'd3);

  always_comb begin
    stb_eff = i_req_stb;
    if (lock_hold && i_req_lock[owner]) stb_eff = i_req_stb & onehot(owner);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_cnt  <= 2'd0;
      lock_hold <= 1'b0;
    end else if (rsp_done) begin
      if (keep_ptr) begin
        lock_cnt  <= lock_cnt + 2'd1;
        lock_hold <= 1'b1;
      end else begin
        lock_cnt  <= 2'd0;
        lock_hold <= 1'b0;
      end
    end
  end
`else
  assign keep_ptr = 1'b0;
  assign stb_eff  = i_req_stb;
`endif

  alu_arb_rr u_rr (
    .stb   (stb_eff),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign o_req_busy  = (state == ST_IDLE) ? ~grant : 2'b11;
  assign o_alu_valid = o_alu_ce;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      tmo_cnt     <= '0;
      o_alu_ce    <= 1'b0;
      o_alu_op    <= '0;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_rsp_valid <= 2'b00;
      o_rsp_c     <= '0;
      o_rsp_f     <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      o_alu_ce    <= 1'b0;
      o_rsp_valid <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            owner    <= grant[1];
            rr_ptr   <= ~grant[1];
            o_alu_op <= grant[1] ? i_req_op[7:4]  : i_req_op[3:0];
            o_alu_a  <= grant[1] ? i_req_a[63:32] : i_req_a[31:0];
            o_alu_b  <= grant[1] ? i_req_b[63:32] : i_req_b[31:0];
            o_alu_ce <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rsp_done) begin
            o_rsp_valid <= onehot(owner);
            state       <= ST_IDLE;
            if (keep_ptr) rr_ptr <= owner;
            // Illegal ops and timeouts both return zeroed result and flags.
            if (i_alu_valid && !i_alu_illegal) begin
              o_rsp_c   <= i_alu_c;
              o_rsp_f   <= i_alu_f;
              o_rsp_err <= 1'b0;
            end else begin
              o_rsp_c   <= '0;
              o_rsp_f   <= '0;
              o_rsp_err <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
